ex_stage: RTL and testbench

- Execute stage of the 16-bit pipelined CPU. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Computes the ALU / load-half result, keeps the Z/V/N flag register, and resolves branch, call and ret.
- Squashes wrong-path instructions after a redirect, latches a sticky halt, and registers everything into the EX/MEM boundary for the memory stage.

---
 rtl/wisc_pkg.sv | 60 ++++++
 rtl/ex_stage_if.sv | 58 +++++
 rtl/wisc_alu.sv | 63 ++++++
 rtl/ex_stage.sv | 124 ++++++++++++
 tb/tb_ex_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared types and helpers for the 16-bit WISC pipeline: ALU opcodes, branch
// conditions, flag bit positions and saturating byte arithmetic.
package wisc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_PADDSB = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_NOR    = 3'd4,
    ALU_SLL    = 3'd5,
    ALU_SRL    = 3'd6,
    ALU_SRA    = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    BR_NEQ    = 3'd0,
    BR_EQ     = 3'd1,
    BR_GT     = 3'd2,
    BR_LT     = 3'd3,
    BR_GTE    = 3'd4,
    BR_LTE    = 3'd5,
    BR_OVFL   = 3'd6,
    BR_UNCOND = 3'd7
  } br_cond_t;

  // flags are packed {Z,V,N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam int SQUASH_DEPTH_DEF = 2;

  function automatic logic [7:0] sat_add8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] s;
    s = x + y;
    if ((x[7] == y[7]) && (s[7] != x[7])) begin
      return x[7] ? 8'h80 : 8'h7F;
    end
    return s;
  endfunction

  function automatic logic br_taken(input br_cond_t c, input logic [2:0] f);
    logic z, v, n;
    z = f[FLAG_Z];
    v = f[FLAG_V];
    n = f[FLAG_N];
    case (c)
      BR_NEQ:  return !z;
      BR_EQ:   return z;
      BR_GT:   return !z && !n;
      BR_LT:   return n;
      BR_GTE:  return z || !n;
      BR_LTE:  return n || z;
      BR_OVFL: return v;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle. The upstream side (ID/EX register or a
// bench) uses the master modport; the execute stage uses the slave modport.
interface ex_stage_if;

  logic        RegWrite_in;
  logic        mem_to_reg_in;
  logic        reg_to_mem_in;
  logic        alu_src_in;
  logic        load_half_in;
  logic        half_spec_in;
  logic        branch_in;
  logic        call_in;
  logic        ret_in;
  logic        hlt_in;
  logic [2:0]  alu_op_in;
  logic [2:0]  branch_cond_in;
  logic [3:0]  shift_in;
  logic [7:0]  load_half_imm_in;
  logic [11:0] call_target_in;
  logic [15:0] rd_data_1_in;
  logic [15:0] rd_data_2_in;
  logic [15:0] sign_ext_in;
  logic [15:0] PC_in;
  logic [3:0]  reg_rd_in;

  logic        RegWrite_out;
  logic        mem_to_reg_out;
  logic        reg_to_mem_out;
  logic [15:0] alu_result_out;
  logic [15:0] store_data_out;
  logic [3:0]  reg_rd_out;
  logic        redirect_out;
  logic [15:0] redirect_pc_out;
  logic [2:0]  flags_out;
  logic        halted_out;
  logic [3:0]  squash_cnt_dbg;

  modport master (
    output RegWrite_in, mem_to_reg_in, reg_to_mem_in, alu_src_in, load_half_in,
           half_spec_in, branch_in, call_in, ret_in, hlt_in, alu_op_in,
           branch_cond_in, shift_in, load_half_imm_in, call_target_in,
           rd_data_1_in, rd_data_2_in, sign_ext_in, PC_in, reg_rd_in,
    input  RegWrite_out, mem_to_reg_out, reg_to_mem_out, alu_result_out,
           store_data_out, reg_rd_out, redirect_out, redirect_pc_out,
           flags_out, halted_out, squash_cnt_dbg
  );

  modport slave (
    input  RegWrite_in, mem_to_reg_in, reg_to_mem_in, alu_src_in, load_half_in,
           half_spec_in, branch_in, call_in, ret_in, hlt_in, alu_op_in,
           branch_cond_in, shift_in, load_half_imm_in, call_target_in,
           rd_data_1_in, rd_data_2_in, sign_ext_in, PC_in, reg_rd_in,
    output RegWrite_out, mem_to_reg_out, reg_to_mem_out, alu_result_out,
           store_data_out, reg_rd_out, redirect_out, redirect_pc_out,
           flags_out, halted_out, squash_cnt_dbg
  );

endinterface

// File: rtl/wisc_alu.sv
// Combinational ALU: saturating ADD/SUB/PADDSB, logic and shifts. Produces the
// result plus which flags this op writes (flag_we) and their new values.
module wisc_alu
  import wisc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  alu_op_t     op,
  input  logic [3:0]  shamt,
  output logic [15:0] result,
  output logic [2:0]  flag_we,
  output logic [2:0]  flag_val
);

  logic [15:0] sum, diff;
  logic        add_ovf, sub_ovf;

  always_comb begin
    sum      = a + b;
    diff     = a - b;
    add_ovf  = (a[15] == b[15]) && (sum[15] != a[15]);
    sub_ovf  = (a[15] != b[15]) && (diff[15] != a[15]);
    result   = '0;
    flag_we  = '0;
    flag_val = '0;
    case (op)
      ALU_ADD: begin
        result           = add_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : sum;
        flag_we          = 3'b111;
        flag_val[FLAG_V] = add_ovf;
      end
      ALU_SUB: begin
        result           = sub_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : diff;
        flag_we          = 3'b111;
        flag_val[FLAG_V] = sub_ovf;
      end
      ALU_PADDSB: result = {sat_add8(a[15:8], b[15:8]), sat_add8(a[7:0], b[7:0])};
      ALU_AND: begin
        result           = a & b;
        flag_we[FLAG_Z]  = 1'b1;
      end
      ALU_NOR: begin
        result           = ~(a | b);
        flag_we[FLAG_Z]  = 1'b1;
      end
      ALU_SLL: begin
        result           = a << shamt;
        flag_we[FLAG_Z]  = 1'b1;
      end
      ALU_SRL: begin
        result           = a >> shamt;
        flag_we[FLAG_Z]  = 1'b1;
      end
      default: begin
        result           = 16'($signed(a) >>> shamt);
        flag_we[FLAG_Z]  = 1'b1;
      end
    endcase
    flag_val[FLAG_Z] = (result == 16'h0000);
    flag_val[FLAG_N] = result[15];
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: result selection, Z/V/N flag register, branch/call/ret
// resolution with wrong-path squash, sticky halt and the EX/MEM register.
module ex_stage
  import wisc_pkg::*;
#(
  parameter int SQUASH_DEPTH = SQUASH_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  ex_stage_if.slave bus
);

  // stall=1 freezes every register here except redirect_q, which is a strict
  // one-cycle pulse; an instruction is consumed only on a non-stalled edge.
  logic        valid, is_mem, flag_upd, redir_take;
  logic [15:0] op2, alu_res, half_res, result, redir_target;
  logic [2:0]  alu_we, alu_val;

  logic        reg_write_d, reg_write_q, mem_to_reg_d, mem_to_reg_q;
  logic        reg_to_mem_d, reg_to_mem_q, redirect_d, redirect_q;
  logic        halted_d, halted_q;
  logic [15:0] alu_result_d, alu_result_q, store_data_d, store_data_q;
  logic [15:0] redirect_pc_d, redirect_pc_q;
  logic [3:0]  reg_rd_d, reg_rd_q, squash_cnt_d, squash_cnt_q;
  logic [2:0]  flags_d, flags_q;

  wisc_alu u_alu (
    .a        (bus.rd_data_1_in),
    .b        (op2),
    .op       (alu_op_t'(bus.alu_op_in)),
    .shamt    (bus.shift_in),
    .result   (alu_res),
    .flag_we  (alu_we),
    .flag_val (alu_val)
  );

  always_comb begin
    op2      = bus.alu_src_in ? bus.sign_ext_in : bus.rd_data_2_in;
    valid    = (squash_cnt_q == 4'd0) && !halted_q && !stall;
    is_mem   = bus.mem_to_reg_in || bus.reg_to_mem_in;
    half_res = bus.half_spec_in ? {{8{bus.load_half_imm_in[7]}}, bus.load_half_imm_in}
                                : {bus.load_half_imm_in, bus.rd_data_1_in[7:0]};
    if (bus.call_in)           result = bus.PC_in;
    else if (bus.load_half_in) result = half_res;
    else if (is_mem)           result = bus.rd_data_1_in + bus.sign_ext_in;
    else                       result = alu_res;

    // only plain ALU instructions touch the flags
    flag_upd = !(bus.load_half_in || is_mem || bus.branch_in || bus.call_in ||
                 bus.ret_in || bus.hlt_in);
    redir_take = valid && (bus.call_in || bus.ret_in ||
                 (bus.branch_in && br_taken(br_cond_t'(bus.branch_cond_in), flags_q)));
    if (bus.call_in)     redir_target = {bus.PC_in[15:12], bus.call_target_in};
    else if (bus.ret_in) redir_target = bus.rd_data_1_in;
    else                 redir_target = bus.PC_in + bus.sign_ext_in;

    reg_write_d   = reg_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    reg_to_mem_d  = reg_to_mem_q;
    alu_result_d  = alu_result_q;
    store_data_d  = store_data_q;
    reg_rd_d      = reg_rd_q;
    flags_d       = flags_q;
    squash_cnt_d  = squash_cnt_q;
    halted_d      = halted_q;
    redirect_d    = redir_take;
    redirect_pc_d = redir_take ? redir_target : redirect_pc_q;

    if (!stall) begin
      reg_write_d  = valid && bus.RegWrite_in && !bus.hlt_in;
      mem_to_reg_d = valid && bus.mem_to_reg_in && !bus.hlt_in;
      reg_to_mem_d = valid && bus.reg_to_mem_in && !bus.hlt_in;
      alu_result_d = result;
      store_data_d = bus.rd_data_2_in;
      reg_rd_d     = bus.reg_rd_in;
      if (valid && flag_upd) flags_d = (flags_q & ~alu_we) | (alu_val & alu_we);
      if (redir_take)                 squash_cnt_d = 4'(SQUASH_DEPTH);
      else if (squash_cnt_q != 4'd0)  squash_cnt_d = squash_cnt_q - 4'd1;
      halted_d = halted_q || (valid && bus.hlt_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_to_mem_q  <= 1'b0;
      alu_result_q  <= '0;
      store_data_q  <= '0;
      reg_rd_q      <= '0;
      flags_q       <= '0;
      squash_cnt_q  <= '0;
      halted_q      <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      reg_to_mem_q  <= reg_to_mem_d;
      alu_result_q  <= alu_result_d;
      store_data_q  <= store_data_d;
      reg_rd_q      <= reg_rd_d;
      flags_q       <= flags_d;
      squash_cnt_q  <= squash_cnt_d;
      halted_q      <= halted_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.RegWrite_out    = reg_write_q;
  assign bus.mem_to_reg_out  = mem_to_reg_q;
  assign bus.reg_to_mem_out  = reg_to_mem_q;
  assign bus.alu_result_out  = alu_result_q;
  assign bus.store_data_out  = store_data_q;
  assign bus.reg_rd_out      = reg_rd_q;
  assign bus.redirect_out    = redirect_q;
  assign bus.redirect_pc_out = redirect_pc_q;
  assign bus.flags_out       = flags_q;
  assign bus.halted_out      = halted_q;
  assign bus.squash_cnt_dbg  = squash_cnt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: each cycle's expected EX/MEM response is queued
// by the driver and checked by an independent monitor after the clock edge.
module tb_ex_stage;
  import wisc_pkg::*;

  typedef struct packed {
    logic [7:0]  id;
    logic        rw;
    logic        m2r;
    logic        r2m;
    logic        chk;
    logic [15:0] res;
    logic [15:0] sd;
    logic [2:0]  fl;
    logic        redir;
    logic [15:0] rpc;
    logic        halt;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic clk, rst, stall;
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int vid = 0;

  ex_stage_if bus();

  ex_stage #(.SQUASH_DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clr();
    rst = 1'b0;  stall = 1'b0;
    bus.RegWrite_in = 1'b0;  bus.mem_to_reg_in = 1'b0;  bus.reg_to_mem_in = 1'b0;
    bus.alu_src_in = 1'b0;   bus.load_half_in = 1'b0;   bus.half_spec_in = 1'b0;
    bus.branch_in = 1'b0;    bus.call_in = 1'b0;        bus.ret_in = 1'b0;
    bus.hlt_in = 1'b0;       bus.alu_op_in = 3'd0;      bus.branch_cond_in = 3'd0;
    bus.shift_in = 4'd0;     bus.load_half_imm_in = 8'h00;
    bus.call_target_in = 12'h000;
    bus.rd_data_1_in = 16'h0; bus.rd_data_2_in = 16'h0;
    bus.sign_ext_in = 16'h0;  bus.PC_in = 16'h0;        bus.reg_rd_in = 4'd0;
  endtask

  task automatic alu(input alu_op_t op, input logic [15:0] a, input logic [15:0] b);
    clr();
    bus.alu_op_in = op;  bus.rd_data_1_in = a;  bus.rd_data_2_in = b;
    bus.RegWrite_in = 1'b1;  bus.reg_rd_in = 4'd3;
  endtask

  task automatic br(input br_cond_t c, input logic [15:0] pc, input logic [15:0] off);
    clr();
    bus.branch_in = 1'b1;  bus.branch_cond_in = c;  bus.PC_in = pc;  bus.sign_ext_in = off;
  endtask

  // ctl = {rw, m2r, r2m, chk_result}; rh = {redirect, halted}
  function automatic exp_t mk(input logic [3:0] ctl, input logic [15:0] res,
                              input logic [15:0] sd, input logic [2:0] fl,
                              input logic [1:0] rh, input logic [15:0] rpc);
    exp_t e;
    e.id = 8'd0;  {e.rw, e.m2r, e.r2m, e.chk} = ctl;
    e.res = res;  e.sd = sd;  e.fl = fl;
    {e.redir, e.halt} = rh;  e.rpc = rpc;
    return e;
  endfunction

  task automatic go(input exp_t e);
    e.id = vid[7:0];
    vid++;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // scoreboard monitor
  task automatic cmp(input logic [7:0] id, input string name,
                     input logic [15:0] got, input logic [15:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL v%0d %s: got %h expected %h", id, name, got, want);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      cmp(e.id, "RegWrite_out",   16'(bus.RegWrite_out),   16'(e.rw));
      cmp(e.id, "mem_to_reg_out", 16'(bus.mem_to_reg_out), 16'(e.m2r));
      cmp(e.id, "reg_to_mem_out", 16'(bus.reg_to_mem_out), 16'(e.r2m));
      cmp(e.id, "flags_out",      16'(bus.flags_out),      16'(e.fl));
      cmp(e.id, "redirect_out",   16'(bus.redirect_out),   16'(e.redir));
      cmp(e.id, "halted_out",     16'(bus.halted_out),     16'(e.halt));
      if (e.chk) begin
        cmp(e.id, "alu_result_out", bus.alu_result_out, e.res);
        cmp(e.id, "store_data_out", bus.store_data_out, e.sd);
      end
      if (e.redir) cmp(e.id, "redirect_pc_out", bus.redirect_pc_out, e.rpc);
    end
  end

  // directed stimulus
  initial begin
    clr();
    rst = 1'b1;
    @(negedge clk);
    // reset, also with stall asserted
    rst = 1'b1;                go(mk(4'b0001, 16'h0000, 16'h0000, 3'b000, 2'b00, 16'h0));
    rst = 1'b1; stall = 1'b1;  go(mk(4'b0001, 16'h0000, 16'h0000, 3'b000, 2'b00, 16'h0));
    // saturating ADD/SUB
    alu(ALU_ADD, 16'h7000, 16'h2000); go(mk(4'b1001, 16'h7FFF, 16'h2000, 3'b010, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h8000, 16'h8000); go(mk(4'b1001, 16'h8000, 16'h8000, 3'b011, 2'b00, 16'h0));
    alu(ALU_SUB, 16'h0005, 16'h0005); go(mk(4'b1001, 16'h0000, 16'h0005, 3'b100, 2'b00, 16'h0));
    // taken EQ branch, two squashed slots, third passes
    br(BR_EQ, 16'h0010, 16'hFFFC);    go(mk(4'b0000, 16'h0, 16'h0, 3'b100, 2'b10, 16'h000C));
    alu(ALU_ADD, 16'h0001, 16'h0001); go(mk(4'b0000, 16'h0, 16'h0, 3'b100, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0001, 16'h0001); go(mk(4'b0000, 16'h0, 16'h0, 3'b100, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0001, 16'h0002); go(mk(4'b1001, 16'h0003, 16'h0002, 3'b000, 2'b00, 16'h0));
    // not-taken LT branch
    br(BR_LT, 16'h0100, 16'h0004);    go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b00, 16'h0));
    // logic and shifts (Z only)
    alu(ALU_AND, 16'hF0F0, 16'h0F0F); go(mk(4'b1001, 16'h0000, 16'h0F0F, 3'b100, 2'b00, 16'h0));
    alu(ALU_NOR, 16'h0000, 16'h0000); go(mk(4'b1001, 16'hFFFF, 16'h0000, 3'b000, 2'b00, 16'h0));
    alu(ALU_SRA, 16'h8000, 16'h0000); bus.shift_in = 4'd4;
    go(mk(4'b1001, 16'hF800, 16'h0000, 3'b000, 2'b00, 16'h0));
    alu(ALU_SLL, 16'h0001, 16'h0000); bus.shift_in = 4'd15;
    go(mk(4'b1001, 16'h8000, 16'h0000, 3'b000, 2'b00, 16'h0));
    alu(ALU_SRL, 16'h8000, 16'h0000); bus.shift_in = 4'd15;
    go(mk(4'b1001, 16'h0001, 16'h0000, 3'b000, 2'b00, 16'h0));
    // PADDSB, register and immediate operand
    alu(ALU_PADDSB, 16'h7F80, 16'h0180); go(mk(4'b1001, 16'h7F80, 16'h0180, 3'b000, 2'b00, 16'h0));
    alu(ALU_PADDSB, 16'h1020, 16'hDEAD); bus.alu_src_in = 1'b1; bus.sign_ext_in = 16'h0102;
    go(mk(4'b1001, 16'h1122, 16'hDEAD, 3'b000, 2'b00, 16'h0));
    alu(ALU_SUB, 16'h0001, 16'h0002); go(mk(4'b1001, 16'hFFFF, 16'h0002, 3'b001, 2'b00, 16'h0));
    // LHB / LLB leave flags alone
    alu(ALU_ADD, 16'h1234, 16'h0000); bus.load_half_in = 1'b1; bus.load_half_imm_in = 8'hAB;
    go(mk(4'b1001, 16'hAB34, 16'h0000, 3'b001, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h1234, 16'h0000); bus.load_half_in = 1'b1; bus.half_spec_in = 1'b1;
    bus.load_half_imm_in = 8'h80;
    go(mk(4'b1001, 16'hFF80, 16'h0000, 3'b001, 2'b00, 16'h0));
    // LW / SW address: unsaturated rd1 + sign_ext
    alu(ALU_ADD, 16'h7FFF, 16'h1111); bus.mem_to_reg_in = 1'b1; bus.sign_ext_in = 16'h0002;
    go(mk(4'b1101, 16'h8001, 16'h1111, 3'b001, 2'b00, 16'h0));
    clr(); bus.reg_to_mem_in = 1'b1; bus.rd_data_1_in = 16'h0100; bus.sign_ext_in = 16'hFFFF;
    bus.rd_data_2_in = 16'hBEEF;
    go(mk(4'b0011, 16'h00FF, 16'hBEEF, 3'b001, 2'b00, 16'h0));
    // CALL then RET
    clr(); bus.call_in = 1'b1; bus.RegWrite_in = 1'b1; bus.reg_rd_in = 4'd15;
    bus.PC_in = 16'h3005; bus.call_target_in = 12'h123;
    go(mk(4'b1001, 16'h3005, 16'h0000, 3'b001, 2'b10, 16'h3123));
    alu(ALU_ADD, 16'h7000, 16'h2000); go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h7000, 16'h2000); go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b00, 16'h0));
    clr(); bus.ret_in = 1'b1; bus.rd_data_1_in = 16'h3005;
    go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b10, 16'h3005));
    alu(ALU_ADD, 16'h0001, 16'h0001); go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0001, 16'h0001); go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b00, 16'h0));
    // branch held by a 3-cycle stall, then a single pulse
    for (int i = 0; i < 3; i++) begin
      br(BR_LT, 16'h0200, 16'h0010); stall = 1'b1;
      go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b00, 16'h0));
    end
    br(BR_LT, 16'h0200, 16'h0010);     go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b10, 16'h0210));
    alu(ALU_ADD, 16'h7000, 16'h2000); stall = 1'b1;
    go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h7000, 16'h2000); go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h7000, 16'h2000); go(mk(4'b0000, 16'h0, 16'h0, 3'b001, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0001, 16'h0001); go(mk(4'b1001, 16'h0002, 16'h0001, 3'b000, 2'b00, 16'h0));
    // HLT in a squashed slot is ignored
    br(BR_UNCOND, 16'h0400, 16'h0001); go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b10, 16'h0401));
    clr(); bus.hlt_in = 1'b1;          go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0001, 16'h0001);  go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0002, 16'h0002);  go(mk(4'b1001, 16'h0004, 16'h0002, 3'b000, 2'b00, 16'h0));
    // reset with one squash slot still pending
    br(BR_UNCOND, 16'h0500, 16'h0002); go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b10, 16'h0502));
    alu(ALU_ADD, 16'h0001, 16'h0001);  go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0001, 16'h0001); rst = 1'b1;
    go(mk(4'b0001, 16'h0000, 16'h0000, 3'b000, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0002, 16'h0003);  go(mk(4'b1001, 16'h0005, 16'h0003, 3'b000, 2'b00, 16'h0));
    // sticky halt, cleared only by reset
    clr(); bus.hlt_in = 1'b1;          go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b01, 16'h0));
    alu(ALU_ADD, 16'h7000, 16'h2000);  go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b01, 16'h0));
    br(BR_UNCOND, 16'h0600, 16'h0001); go(mk(4'b0000, 16'h0, 16'h0, 3'b000, 2'b01, 16'h0));
    clr(); rst = 1'b1;                 go(mk(4'b0001, 16'h0000, 16'h0000, 3'b000, 2'b00, 16'h0));
    alu(ALU_ADD, 16'h0003, 16'h0004);  go(mk(4'b1001, 16'h0007, 16'h0004, 3'b000, 2'b00, 16'h0));
    clr();
    // final report
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
